// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multiply/divide unit and its interface.
package cpu_pkg;

  localparam int XLEN = 32;

  // M-extension funct7, used by the decode logic that raises start.
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_if.sv
// Pipeline <-> multiply/divide unit signals; master is the EX stage, slave is the unit.
interface ex_muldiv_if;
  import cpu_pkg::*;

  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            stall;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, flush, funct3, rs1, rs2,
                  input  stall, busy, done, result);
  modport slave  (input  start, flush, funct3, rs1, rs2,
                  output stall, busy, done, result);
endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Restoring divider on magnitudes: load performs the first step, each step adds one quotient bit.
module div_iter
  import cpu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem,
  output logic [5:0]      cnt
);

  logic [XLEN-1:0]   dvs_q;
  logic [2*XLEN-1:0] nxt;

  function automatic logic [2*XLEN-1:0] restore_step(input logic [XLEN-1:0] r,
                                                     input logic [XLEN-1:0] q,
                                                     input logic [XLEN-1:0] d);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    shifted = {r, q[XLEN-1]};
    trial   = shifted - {1'b0, d};
    if (!trial[XLEN]) return {trial[XLEN-1:0], q[XLEN-2:0], 1'b1};
    else              return {shifted[XLEN-1:0], q[XLEN-2:0], 1'b0};
  endfunction

  always_comb begin
    nxt = load ? restore_step('0, dividend, divisor) : restore_step(rem, quo, dvs_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo   <= '0;
      rem   <= '0;
      dvs_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      {rem, quo} <= nxt;
      dvs_q      <= divisor;
      cnt        <= 6'd1;
    end else if (step) begin
      {rem, quo} <= nxt;
      cnt        <= cnt + 6'd1;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage, stalling the pipeline until done.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier instead of shift-add.
module ex_muldiv #(
  parameter int XLEN = cpu_pkg::XLEN
) (
  input logic         clk,
  input logic         rst_n,
  ex_muldiv_if.slave  mif
);
  import cpu_pkg::*;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state;
  muldiv_op_e      op_q;
  logic            neg_q, neg_r, done_q;
  logic [XLEN-1:0] result_q;

  logic            is_div, signed_a, signed_b, sign_a, sign_b, accept, div_special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  logic [XLEN-1:0] quo, rem, quo_fix, rem_fix;
  logic [5:0]      div_cnt;

  // NOTE: every signal driven here gets a default first so no latch can be inferred.
  always_comb begin
    is_div      = mif.funct3[2];
    signed_a    = is_div ? ~mif.funct3[0] : ~(mif.funct3[1] & mif.funct3[0]);
    signed_b    = is_div ? ~mif.funct3[0] : ~mif.funct3[1];
    sign_a      = signed_a & mif.rs1[XLEN-1];
    sign_b      = signed_b & mif.rs2[XLEN-1];
    mag_a       = sign_a ? -mif.rs1 : mif.rs1;
    mag_b       = sign_b ? -mif.rs2 : mif.rs2;
    accept      = (state == S_IDLE) & mif.start & ~mif.flush;
    div_special = (mif.rs2 == '0) |
                  (~mif.funct3[0] & (mif.rs1 == INT_MIN) & (mif.rs2 == '1));
    // Zero divisor: quotient all ones, remainder = dividend. Overflow: quotient INT_MIN, remainder 0.
    if (mif.rs2 == '0) special_res = mif.funct3[1] ? mif.rs1 : '1;
    else               special_res = mif.funct3[1] ? '0 : INT_MIN;
    quo_fix     = neg_q ? -quo : quo;
    rem_fix     = neg_r ? -rem : rem;
  end

  div_iter u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept & is_div & ~div_special),
    .step     ((state == S_DIV) && (div_cnt != 6'd32)),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo      (quo),
    .rem      (rem),
    .cnt      (div_cnt)
  );

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN-1:0] fprod;
  logic [XLEN-1:0]          fast_res;
  always_comb begin
    fa       = $signed({sign_a, mif.rs1});
    fb       = $signed({sign_b, mif.rs2});
    fprod    = fa * fb;
    fast_res = (mif.funct3[1:0] == 2'b00) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
  end
`else
  logic [2*XLEN-1:0] prod_q, prod_nxt, prod_fix;
  logic [XLEN-1:0]   mcand_q;
  logic [4:0]        mul_cnt;
  logic [XLEN:0]     mul_sum;
  // prod_q low half starts as the multiplier and is shifted out as the product grows in.
  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
    prod_fix = neg_q ? -prod_nxt : prod_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, since result and sign flags must read 0 after reset.
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifndef MULDIV_FAST_MUL_EN
      prod_q   <= '0;
      mcand_q  <= '0;
      mul_cnt  <= '0;
`endif
    end else if (mif.flush) begin
      state  <= S_IDLE;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (mif.start) begin
            op_q  <= muldiv_op_e'(mif.funct3);
            neg_q <= sign_a ^ sign_b;
            neg_r <= sign_a;
            if (is_div) begin
              if (div_special) begin
                result_q <= special_res;
                done_q   <= 1'b1;
                state    <= S_DONE;
              end else begin
                state <= S_DIV;
              end
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              result_q <= fast_res;
              done_q   <= 1'b1;
              state    <= S_DONE;
`else
              prod_q   <= {{XLEN{1'b0}}, mag_b};
              mcand_q  <= mag_a;
              mul_cnt  <= '0;
              state    <= S_MUL;
`endif
            end
          end
        end
        S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
          state <= S_IDLE;
`else
          prod_q  <= prod_nxt;
          mul_cnt <= mul_cnt + 5'd1;
          if (mul_cnt == 5'd31) begin
            result_q <= (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
`endif
        end
        S_DIV: begin
          if (div_cnt == 6'd32) begin
            result_q <= (op_q == OP_REM || op_q == OP_REMU) ? rem_fix : quo_fix;
            done_q   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mif.busy   = (state != S_IDLE);
  assign mif.done   = done_q;
  assign mif.result = result_q;
  assign mif.stall  = rst_n & ~mif.flush &
                      (((state == S_IDLE) & mif.start) | (state == S_MUL) | (state == S_DIV));

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage. It consumes the operands and funct3 latched in the ID/EX pipeline register when that register holds an M-extension instruction. It holds the front of the pipeline with `stall` until the result is ready, then presents the 32-bit result for one cycle so the EX/MEM register captures it together with the rest of the instruction.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: EX holds a valid M-extension op (OP opcode, funct7 = 0000001, pc ≠ 0).
- `flush` in 1: kill the in-flight op (redirect/trap).
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1` in 32: forwarded operand A.
- `rs2` in 32: forwarded operand B.
- `stall` out 1: freezes IF/ID/EX and bubbles MEM while the unit works.
- `busy` out 1: FSM not in IDLE.
- `done` out 1: single-cycle result-valid pulse.
- `result` out 32: result, valid while `done` = 1.

## Operation
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - `start` = 1 and funct3[2] = 0 → MUL.
  - `start` = 1 and funct3[2] = 1 → DIV, or → DONE directly if rs2 = 0 or signed overflow.
  - Operands and funct3 are registered on the same edge.
- Sign handling:
  - Signed operands (MULH/DIV/REM: both; MULHSU: rs1 only) are converted to magnitudes.
  - The result sign is recorded: product sign = signA ^ signB; quotient sign = signA ^ signB; remainder sign = signA.
- MUL: radix-2 shift-add over a 64-bit accumulator, one bit per cycle, 32 cycles, then DONE.
  - Final negation is applied if the sign flag is set.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- DIV: restoring division, one quotient bit per cycle, 32 cycles, then DONE. Quotient and remainder are sign-corrected on entry to DONE.
- Special cases resolved in IDLE, with no iteration:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DONE: `done` = 1, `result` driven, then → IDLE unconditionally. `start` is ignored in DONE; it still reflects the retiring instruction.
- `result` register holds its last value after DONE until the next completion.
- `stall` = (IDLE & start & ~flush) | MUL | DIV.
- `busy` = state ≠ IDLE.
- `flush` priority:
  - It overrides `start` and every state.
  - The next state is IDLE; `done` is not asserted for the killed op; `stall` drops in the same cycle (combinational).
- Reset (`rst_n` low, at any time including mid-operation):
  - State IDLE; all datapath registers, `result`, and the sign flags are 0.
  - `done` = 0, `busy` = 0, and `stall` is forced to 0.

## Timing
- Start accepted at edge E0 (cycle 0, `stall` already high combinationally).
- Iterative ops:
  - Iteration cycles 1–32 with `stall` = 1.
  - Cycle 33 is DONE: `done` = 1, `stall` = 0, and the pipeline advances on the following edge.
- Special-case division: cycle 1 is DONE.
- Back-to-back M ops: the second op's `start` is seen in IDLE at cycle 34 at the earliest, with no extra bubble beyond IDLE→start.
- `stall` and `done` are never both 1.
- `busy` is 1 from cycle 1 through DONE inclusive.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - Multiplies use a single combinational 33×33 signed multiply registered at E0.
  - IDLE → DONE directly, so MUL latency is 1 cycle (DONE at cycle 1).
  - The MUL state is unused.
- `MULDIV_FAST_MUL_EN` undefined: 32-cycle shift-add path as above. Divide behaviour is identical in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - `XLEN`.
  - `muldiv_op_e` (funct3 encodings above).
  - `muldiv_state_e` {IDLE, MUL, DIV, DONE}.
  - The M-extension funct7 constant 7'b0000001, used by the decode/start logic.
- One sub-module, `div_iter`: the restoring-division datapath. It takes magnitude inputs, has a step enable, and exposes quotient/remainder registers plus a counter.
- Sign conversion and the FSM remain in `ex_muldiv`.

## Test plan
- MUL rs1 = 7, rs2 = 0xFFFFFFFD → `result` = 0xFFFFFFEB with `done` at cycle 33 (cycle 1 with `MULDIV_FAST_MUL_EN`); `stall` high for cycles 0–32.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF; MULH 0x80000000 × 0x80000000 → 0x40000000.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF and REM 0x1234 / 0 → 0x1234, both with `done` at cycle 1; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0 at cycle 1.
- DIV started, `flush` at cycle 10 → `stall` = 0 in cycle 10, IDLE at cycle 11, no `done`; a new MUL 3 × 4 started at cycle 12 → 12.
- `rst_n` low at cycle 20 of MUL → `busy`/`stall`/`done`/`result` = 0 immediately; after release, `start` = 1 begins a fresh op with the correct result.
